network_run_controller: RTL and testbench
=========================================

Name: network_run_controller

Overview:
- Sequences the spiking network core: accepts run/clear/sync commands, drives the network enable and clear strobes, and emits per-timestep output-valid and end-of-run sync toward the network sink.
- Honours sink backpressure: the network only advances when the sink can take that timestep's output.
- Sits between the host command path and the network/sink pair; replaces free-running enable with counted, flow-controlled runs.

Parameters:
RUN_WIDTH, 16, width of the RUN command argument (timesteps per command)
CNT_WIDTH, 32, width of the run_count timestep counter since last clear
CLR_CYCLES, 2, cycles net_clear is held per clear (must be >= 1)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
cmd_valid  input  1  command present
cmd_ready  output  1  controller accepts a command this cycle
cmd_op  input  2  00 NOP, 01 RUN, 10 CLR, 11 SYNC
cmd_arg  input  RUN_WIDTH  timestep count for RUN; ignored otherwise
net_en  output  1  network advances one timestep this cycle
net_clear  output  1  network state clear strobe
out_ready  input  1  sink can accept a timestep output/sync this cycle
out_valid  output  1  a timestep output or sync marker is presented to the sink
out_sync  output  1  marks out_valid beat as end-of-run sync marker
busy  output  1  state != IDLE
run_count  output  CNT_WIDTH  timesteps executed since last clear, saturating

Behaviour:
- One clock. Reset is synchronous and active-high.
- FSM states: IDLE, RUN, SYNC, CLEAR. Registers: state, remaining (RUN_WIDTH), clr_cnt, run_count.
- Reset (rst=1 at an edge): state<=CLEAR, clr_cnt<=CLR_CYCLES-1, remaining<=0, run_count<=0.
  - Outputs while in reset and after it: net_clear=1, net_en=0, out_valid=0, out_sync=0, cmd_ready=0, busy=1.
  - After rst falls, net_clear stays high exactly CLR_CYCLES cycles, then IDLE.
- Reset mid-operation aborts immediately: no sync emitted, remaining discarded, clear sequence restarts.
- cmd_ready = (state==IDLE). A command is accepted on a cycle with cmd_valid && cmd_ready.
- IDLE on accept:
  - NOP: stay IDLE.
  - RUN with arg>0: remaining<=arg, go RUN.
  - RUN with arg=0: go SYNC; no timestep.
  - CLR: clr_cnt<=CLR_CYCLES-1, go CLEAR.
  - SYNC: go SYNC.
- RUN:
  - net_en = out_valid = out_ready. This is a combinational path out_ready->net_en; there is no other comb path.
  - out_sync=0.
  - Each net_en cycle: remaining--, run_count++ (holds at all-ones once saturated).
  - net_en cycle with remaining==1: go SYNC.
  - out_ready=0: hold; no enable, no count.
- SYNC:
  - out_valid=1, out_sync=1, net_en=0.
  - Leave to IDLE on the cycle out_ready=1; otherwise hold with both asserted (sink handshake must not drop valid).
- CLEAR:
  - net_clear=1, net_en=0, out_valid=0, run_count<=0.
  - clr_cnt decrements each cycle; at 0 go IDLE.
- Latency:
  - A RUN accepted at cycle t gives its first net_en at t+1 if out_ready.
  - A RUN of N with continuous out_ready occupies N RUN cycles + 1 SYNC cycle; cmd_ready returns at t+N+2.
- net_en and net_clear are never asserted together.
- out_sync is never asserted without out_valid.

Test Plan:
- Reset held 3 cycles, then released, CLR_CYCLES=2 -> net_clear=1 during reset and for 2 cycles after; cmd_ready=1 on 3rd cycle after release; run_count=0.
- RUN arg=3, out_ready=1 constant -> net_en high exactly 3 consecutive cycles starting 1 cycle after accept, then one out_valid&&out_sync beat; run_count=3; cmd_ready back after 5 cycles.
- RUN arg=4, out_ready pattern 1,0,1,1,0,0,1 then 0 for 2 cycles then 1 -> net_en only on ready cycles, totalling 4; sync held valid through the 2 not-ready cycles, retires on the ready; run_count=4.
- RUN arg=0, then SYNC -> zero net_en, exactly two sync beats, run_count unchanged; NOP accepted without leaving IDLE.
- Run 5 steps, then CLR -> run_count 5 before, 0 after; net_clear 2 cycles; no net_en during clear; cmd_valid held during CLEAR is not accepted until IDLE.
- CNT_WIDTH=4: RUN arg=20 -> run_count saturates at 15, 20 net_en pulses; rst asserted after 2 steps of a RUN 5 -> no sync, net_clear sequence, run_count=0.

Source files
------------

// File: rtl/network_run_controller.sv
// Sequences the spiking network core: counted, sink-flow-controlled runs with clear and sync markers.
// Only comb path is out_ready -> net_en/out_valid while running; everything else is registered state decode.
module network_run_controller #(
  parameter int RUN_WIDTH  = 16,
  parameter int CNT_WIDTH  = 32,
  parameter int CLR_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [RUN_WIDTH-1:0] cmd_arg,
  output logic                 net_en,
  output logic                 net_clear,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic                 out_sync,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] run_count
);

  localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [CLR_W-1:0] CLR_INIT = CLR_W'(CLR_CYCLES - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] SYNC  = 2'd2;
  localparam logic [1:0] CLEAR = 2'd3;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_RUN  = 2'b01;
  localparam logic [1:0] OP_CLR  = 2'b10;
  localparam logic [1:0] OP_SYNC = 2'b11;

  logic [1:0]           state;
  logic [RUN_WIDTH-1:0] remaining;
  logic [CLR_W-1:0]     clr_cnt;
  logic                 accept;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign net_clear = (state == CLEAR);
  // A timestep only advances when the sink can take its output in the same cycle.
  assign net_en    = (state == RUN) && out_ready;
  assign out_valid = net_en || (state == SYNC);
  assign out_sync  = (state == SYNC);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CLEAR;
      clr_cnt   <= CLR_INIT;
      remaining <= '0;
      run_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            case (cmd_op)
              OP_RUN: begin
                if (cmd_arg != '0) begin
                  remaining <= cmd_arg;
                  state     <= RUN;
                end else begin
                  state <= SYNC;
                end
              end
              OP_CLR: begin
                clr_cnt <= CLR_INIT;
                state   <= CLEAR;
              end
              OP_SYNC: state <= SYNC;
              OP_NOP:  state <= IDLE;
              default: state <= IDLE;
            endcase
          end
        end
        RUN: begin
          if (out_ready) begin
            remaining <= remaining - RUN_WIDTH'(1);
            if (run_count != '1) run_count <= run_count + CNT_WIDTH'(1);
            if (remaining == RUN_WIDTH'(1)) state <= SYNC;
          end
        end
        SYNC: begin
          if (out_ready) state <= IDLE;
        end
        CLEAR: begin
          run_count <= '0;
          if (clr_cnt == '0) state <= IDLE;
          else clr_cnt <= clr_cnt - CLR_W'(1);
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_network_run_controller.sv
// Bench for network_run_controller: directed scenarios plus random commands/readiness
// checked against a transaction-level model (steps left, sync pending, saturating count).
module tb_network_run_controller;
  localparam int RW  = 16;
  localparam int CW  = 4;
  localparam int CC  = 2;
  localparam int MAXC = (1 << CW) - 1;

  localparam logic [1:0] NOP = 2'b00, RUN = 2'b01, CLR = 2'b10, SYN = 2'b11;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [RW-1:0] cmd_arg = '0;
  logic          net_en;
  logic          net_clear;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic          out_sync;
  logic          busy;
  logic [CW-1:0] run_count;

  network_run_controller #(.RUN_WIDTH(RW), .CNT_WIDTH(CW), .CLR_CYCLES(CC)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .net_en(net_en), .net_clear(net_clear),
    .out_ready(out_ready), .out_valid(out_valid), .out_sync(out_sync),
    .busy(busy), .run_count(run_count)
  );

  always #5 clk = ~clk;

  int compares = 0;
  int fails = 0;
  int model_count = 0;
  int ready_q[$];
  bit rand_ready = 1'b0;

  task automatic check1(input string tag, input logic obs, input logic exp);
    compares++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic checkn(input string tag, input int obs, input int exp);
    compares++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic next_ready();
    int v;
    if (ready_q.size() > 0) begin
      v = ready_q.pop_front();
      return v != 0;
    end
    if (rand_ready) return $urandom_range(0, 1) != 0;
    return 1'b1;
  endfunction

  task automatic do_reset(input int n);
    rst = 1'b1;
    cmd_valid = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      check1("rst_clear", net_clear, 1'b1);
      check1("rst_en", net_en, 1'b0);
      check1("rst_valid", out_valid, 1'b0);
      check1("rst_sync", out_sync, 1'b0);
      check1("rst_ready", cmd_ready, 1'b0);
      check1("rst_busy", busy, 1'b1);
    end
    rst = 1'b0;
    for (int i = 0; i < CC; i++) begin
      #1;
      check1("post_rst_clear", net_clear, 1'b1);
      check1("post_rst_ready", cmd_ready, 1'b0);
      tick();
    end
    #1;
    check1("rel_ready", cmd_ready, 1'b1);
    check1("rel_clear", net_clear, 1'b0);
    checkn("rel_count", int'(run_count), 0);
    model_count = 0;
  endtask

  task automatic issue(input logic [1:0] op, input int arg, input bit hold);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_arg = RW'(arg);
    out_ready = 1'b0;
    #1;
    check1("accept_ready", cmd_ready, 1'b1);
    tick();
    if (!hold) cmd_valid = 1'b0;
  endtask

  // Follows a just-accepted command to completion; cycles counts from the accept edge until IDLE.
  task automatic follow(input logic [1:0] op, input int arg, output int cycles);
    int left;
    int budget;
    logic r;
    cycles = 1;
    if (op == RUN && arg > 0) begin
      left = arg;
      budget = 0;
      while (left > 0 && budget < 300) begin
        r = next_ready();
        out_ready = r;
        #1;
        check1("run_en", net_en, r);
        check1("run_valid", out_valid, r);
        check1("run_sync", out_sync, 1'b0);
        check1("run_clear", net_clear, 1'b0);
        checkn("run_count_step", int'(run_count), model_count);
        tick();
        cycles++;
        budget++;
        if (r) begin
          left--;
          if (model_count < MAXC) model_count++;
        end
      end
      checkn("run_budget", left, 0);
    end
    if (op == RUN || op == SYN) begin
      budget = 0;
      do begin
        r = next_ready();
        out_ready = r;
        #1;
        check1("sync_valid", out_valid, 1'b1);
        check1("sync_flag", out_sync, 1'b1);
        check1("sync_en", net_en, 1'b0);
        check1("sync_clear", net_clear, 1'b0);
        tick();
        cycles++;
        budget++;
      end while (!r && budget < 300);
      check1("sync_budget", r, 1'b1);
    end
    if (op == CLR) begin
      for (int i = 0; i < CC; i++) begin
        out_ready = next_ready();
        #1;
        check1("clr_strobe", net_clear, 1'b1);
        check1("clr_en", net_en, 1'b0);
        check1("clr_valid", out_valid, 1'b0);
        check1("clr_ready", cmd_ready, 1'b0);
        tick();
        cycles++;
      end
      model_count = 0;
    end
    out_ready = 1'b0;
    #1;
    check1("idle_ready", cmd_ready, 1'b1);
    check1("idle_busy", busy, 1'b0);
    check1("idle_en", net_en, 1'b0);
    checkn("idle_count", int'(run_count), model_count);
  endtask

  initial begin
    int cyc;
    logic [1:0] op;
    int arg;

    do_reset(3);

    // RUN 3 with constant readiness: 3 steps, one sync beat, idle 5 cycles after accept.
    issue(RUN, 3, 1'b0);
    follow(RUN, 3, cyc);
    checkn("run3_latency", cyc, 5);
    checkn("run3_count", int'(run_count), 3);

    // RUN 4 with a gappy sink; sync must hold through two not-ready cycles.
    ready_q = '{1, 0, 1, 1, 0, 0, 1, 0, 0, 1};
    issue(RUN, 4, 1'b0);
    follow(RUN, 4, cyc);
    checkn("run4_cycles", cyc, 11);
    checkn("run4_count", int'(run_count), 7);

    issue(RUN, 0, 1'b0);
    follow(RUN, 0, cyc);
    checkn("run0_cycles", cyc, 2);
    issue(SYN, 0, 1'b0);
    follow(SYN, 0, cyc);
    checkn("sync_cycles", cyc, 2);
    issue(NOP, 0, 1'b0);
    follow(NOP, 0, cyc);
    checkn("nop_count", int'(run_count), 7);

    // RUN 5, then CLR with a RUN held on the command bus through the clear.
    issue(RUN, 5, 1'b0);
    follow(RUN, 5, cyc);
    checkn("pre_clr_count", int'(run_count), 12);
    issue(CLR, 0, 1'b0);
    cmd_valid = 1'b1;
    cmd_op = RUN;
    cmd_arg = RW'(2);
    follow(CLR, 0, cyc);
    checkn("post_clr_count", int'(run_count), 0);
    tick();
    cmd_valid = 1'b0;
    follow(RUN, 2, cyc);
    checkn("held_run_count", int'(run_count), 2);

    // Saturation: count tops out at 15 while all 20 steps still happen.
    rand_ready = 1'b1;
    issue(RUN, 20, 1'b0);
    follow(RUN, 20, cyc);
    checkn("sat_count", int'(run_count), MAXC);
    rand_ready = 1'b0;

    // Reset two steps into a RUN of 5: no sync, clear sequence restarts.
    issue(RUN, 5, 1'b0);
    out_ready = 1'b1;
    tick();
    tick();
    #1;
    check1("mid_run_busy", busy, 1'b1);
    check1("mid_run_nosync", out_sync, 1'b0);
    do_reset(1);

    rand_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      op = 2'($urandom_range(0, 3));
      arg = $urandom_range(0, 6);
      issue(op, arg, 1'b0);
      follow(op, arg, cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "bench time limit");
  end
endmodule
